// File: rtl/dispatch_router.sv
// rtl/dispatch_router.sv - dispatch buffer routing renamed instructions to RS/LSQ write ports with CDB snoop
// Holds one rename group, writes it in program order into the issue queues, and keeps held operands awake.
package dispatch_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [15:0]       opcode;
        logic [TAG_W-1:0]  dest_tag;
        logic              src1_rdy;
        logic [TAG_W-1:0]  src1_tag;
        logic [DATA_W-1:0] src1_val;
        logic              src2_rdy;
        logic [TAG_W-1:0]  src2_tag;
        logic [DATA_W-1:0] src2_val;
    } instruction_t;

    typedef struct packed {
        logic              is_valid;
        logic [TAG_W-1:0]  dest_tag;
        logic [DATA_W-1:0] result;
    } writeback_packet_t;
endpackage

module dispatch_router
    import dispatch_pkg::*;
#(
    parameter int PIPE_WIDTH = 2,
    parameter int NUM_RS     = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_flush,
    input  logic [PIPE_WIDTH-1:0]                        i_rename_val,
    input  instruction_t [PIPE_WIDTH-1:0]                i_rename_pkts,
    input  logic [PIPE_WIDTH-1:0][SEL_W-1:0]             i_rename_rs_sel,
    output logic                                         o_rename_rdy,
    input  logic [NUM_RS-1:0][PIPE_WIDTH-1:0]            i_rs_rdys,
    output logic [NUM_RS-1:0][PIPE_WIDTH-1:0]            o_rs_wes,
    output instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0]    o_rs_issue_ports,
    input  writeback_packet_t [PIPE_WIDTH-1:0]           i_cdb_ports,
    output logic [CNT_W-1:0]                             o_stall_cycles
);
    localparam int CW = $clog2(PIPE_WIDTH + 1);

    logic [PIPE_WIDTH-1:0]                      r_valid;
    instruction_t [PIPE_WIDTH-1:0]              r_pkt;
    logic [PIPE_WIDTH-1:0][SEL_W-1:0]           r_sel;
    logic [CNT_W-1:0]                           r_stall_cycles;

    instruction_t [PIPE_WIDTH-1:0]              w_snooped;
    logic [PIPE_WIDTH-1:0]                      w_disp;
    logic [PIPE_WIDTH-1:0]                      w_sel_bad;
    logic                                       w_all_disp;
    logic                                       w_oldest_stall;
    logic [NUM_RS-1:0][PIPE_WIDTH-1:0]          w_wes;
    instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0]  w_ports;

    // Lowest-indexed matching CDB port supplies the value for each not-yet-ready source.
    function automatic instruction_t snoop(input instruction_t pkt,
                                           input writeback_packet_t [PIPE_WIDTH-1:0] cdb);
        instruction_t o;
        logic         h1;
        logic         h2;
        o  = pkt;
        h1 = 1'b0;
        h2 = 1'b0;
        for (int p = 0; p < PIPE_WIDTH; p++) begin
            if (!pkt.src1_rdy && !h1 && cdb[p].is_valid && cdb[p].dest_tag == pkt.src1_tag) begin
                o.src1_rdy = 1'b1;
                o.src1_val = cdb[p].result;
                h1         = 1'b1;
            end
            if (!pkt.src2_rdy && !h2 && cdb[p].is_valid && cdb[p].dest_tag == pkt.src2_tag) begin
                o.src2_rdy = 1'b1;
                o.src2_val = cdb[p].result;
                h2         = 1'b1;
            end
        end
        return o;
    endfunction

    always_comb begin
        w_snooped = r_pkt;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            w_snooped[i] = snoop(r_pkt[i], i_cdb_ports);
        end
    end

    always_comb begin : route
        logic          blocked;
        logic          seen;
        logic          hit;
        logic          go;
        logic [CW-1:0] cnt [NUM_RS];
        blocked        = 1'b0;
        seen           = 1'b0;
        hit            = 1'b0;
        go             = 1'b0;
        w_disp         = '0;
        w_sel_bad      = '0;
        w_wes          = '0;
        w_ports        = '0;
        w_oldest_stall = 1'b0;
        for (int r = 0; r < NUM_RS; r++) begin
            cnt[r] = '0;
        end
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (r_valid[i]) begin
                hit = 1'b0;
                go  = 1'b0;
                // cnt[r] is the next free write port of queue r this cycle
                for (int r = 0; r < NUM_RS; r++) begin
                    if (r_sel[i] == SEL_W'(r)) begin
                        hit = 1'b1;
                        for (int c = 0; c < PIPE_WIDTH; c++) begin
                            if (!blocked && cnt[r] == CW'(c) && i_rs_rdys[r][c]) begin
                                go            = 1'b1;
                                w_wes[r][c]   = 1'b1;
                                w_ports[r][c] = w_snooped[i];
                            end
                        end
                        if (go) begin
                            cnt[r] = cnt[r] + CW'(1);
                        end
                    end
                end
                w_sel_bad[i] = !hit;
                w_disp[i]    = go;
                if (!go) begin
                    blocked = 1'b1;
                end
                if (!seen && !go) begin
                    w_oldest_stall = 1'b1;
                end
                seen = 1'b1;
            end
        end
        w_all_disp = ((r_valid & ~w_disp) == '0);
        if (i_flush) begin
            w_wes   = '0;
            w_ports = '0;
        end
    end

    assign o_rename_rdy     = !i_flush && w_all_disp;
    assign o_rs_wes         = w_wes;
    assign o_rs_issue_ports = w_ports;
    assign o_stall_cycles   = r_stall_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid        <= '0;
            r_pkt          <= '0;
            r_sel          <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_oldest_stall && !i_flush && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (i_flush) begin
                r_valid <= '0;
            end else if (o_rename_rdy && |i_rename_val) begin
                r_valid <= i_rename_val;
                r_pkt   <= i_rename_pkts;
                r_sel   <= i_rename_rs_sel;
            end else begin
                r_valid <= r_valid & ~w_disp;
                for (int i = 0; i < PIPE_WIDTH; i++) begin
                    if (r_valid[i]) begin
                        r_pkt[i] <= w_snooped[i];
                    end
                end
            end
        end
    end

    // An out-of-range queue select never dispatches; flag it so the upstream bug is visible.
    a_sel_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n) (w_sel_bad == '0));

endmodule
